// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared halfword width, output record and length decode for the fetch stage
package fetch_pkg;

  localparam int HW_W = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_c;
  } fetch_out_t;

  function automatic logic is_compressed(input logic [HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_aligner_hw_queue.sv
// rtl/fetch_aligner_hw_queue.sv - circular halfword FIFO, up to two pushes and two pops per cycle
module hw_queue import fetch_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [1:0]      push_i,
  input  logic [HW_W-1:0] push_data0_i,
  input  logic [HW_W-1:0] push_data1_i,
  input  logic [1:0]      pop_i,
  output logic [HW_W-1:0] head0_o,
  output logic [HW_W-1:0] head1_o,
  output logic [CW-1:0]   count_o
);

  logic [HW_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW - 1){1'b0}}, n};
    if (s >= (PW + 1)'(DEPTH)) s = s - (PW + 1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    rd_d  = adv(rd_q, pop_i);
    wr_d  = adv(wr_q, push_i);
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (push_i != 2'd0) mem_q[wr_q] <= push_data0_i;
      if (push_i == 2'd2) mem_q[adv(wr_q, 2'd1)] <= push_data1_i;
    end
  end

  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[adv(rd_q, 2'd1)];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - ROM fetch, halfword realignment and redirect handling
// FETCH_RVC_EN enables 16-bit compressed instructions; otherwise every instruction is 32-bit.
module fetch_aligner import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QUEUE_HW = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] FetchAddr,
  output logic        FetchEn,
  input  logic [31:0] FetchData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [31:0] InstrPc,
  output logic        InstrIsC,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPc
);

  localparam int CW = $clog2(QUEUE_HW + 1);

`ifdef FETCH_RVC_EN
  localparam logic [31:0] PC_MASK    = 32'hFFFF_FFFE;
  localparam logic        RESET_SKIP = RESET_PC[1];
`else
  localparam logic [31:0] PC_MASK    = 32'hFFFF_FFFC;
  localparam logic        RESET_SKIP = 1'b0;
`endif

  logic [31:0]     word_pc_q, word_pc_d, head_pc_q, head_pc_d;
  logic            skip_q, skip_d;
  logic [HW_W-1:0] head0, head1;
  logic [CW-1:0]   count, free;
  logic            head_is_c, redir_skip, instr_valid, handshake;
  logic [1:0]      need, fetch_need, push_num, pop_num;
  fetch_out_t      out_s;

`ifdef FETCH_RVC_EN
  assign head_is_c  = is_compressed(head0);
  assign redir_skip = RedirectPc[1];
`else
  assign head_is_c  = 1'b0;
  assign redir_skip = 1'b0;
`endif

  assign need        = head_is_c ? 2'd1 : 2'd2;
  assign instr_valid = count >= CW'(need);
  assign handshake   = instr_valid & InstrReady & ~RedirectValid;

  // Gate on the current count only, so a same-cycle pop never makes room early.
  assign free       = CW'(QUEUE_HW) - count;
  assign fetch_need = skip_q ? 2'd1 : 2'd2;
  assign FetchEn    = (free >= CW'(fetch_need)) & ~RedirectValid;
  assign FetchAddr  = word_pc_q;
  assign push_num   = FetchEn ? fetch_need : 2'd0;
  assign pop_num    = handshake ? need : 2'd0;

  hw_queue #(.DEPTH(QUEUE_HW)) u_queue (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .flush_i      (RedirectValid),
    .push_i       (push_num),
    .push_data0_i (skip_q ? FetchData[31:16] : FetchData[15:0]),
    .push_data1_i (FetchData[31:16]),
    .pop_i        (pop_num),
    .head0_o      (head0),
    .head1_o      (head1),
    .count_o      (count)
  );

  always_comb begin
    out_s.pc    = head_pc_q;
    out_s.is_c  = instr_valid & head_is_c;
    out_s.instr = 32'h0;
    if (instr_valid) out_s.instr = head_is_c ? {16'h0, head0} : {head1, head0};
  end

  assign InstrValid = instr_valid;
  assign Instr      = out_s.instr;
  assign InstrPc    = out_s.pc;
  assign InstrIsC   = out_s.is_c;

  always_comb begin
    word_pc_d = word_pc_q;
    head_pc_d = head_pc_q;
    skip_d    = skip_q;
    if (RedirectValid) begin
      word_pc_d = RedirectPc & 32'hFFFF_FFFC;
      head_pc_d = RedirectPc & PC_MASK;
      skip_d    = redir_skip;
    end else begin
      if (FetchEn) begin
        word_pc_d = word_pc_q + 32'd4;
        skip_d    = 1'b0;
      end
      if (handshake) head_pc_d = head_pc_q + {29'b0, need, 1'b0};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      word_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      head_pc_q <= RESET_PC & PC_MASK;
      skip_q    <= RESET_SKIP;
    end else begin
      word_pc_q <= word_pc_d;
      head_pc_q <= head_pc_d;
      skip_q    <= skip_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - self-checking bench for fetch_aligner; follows FETCH_RVC_EN when defined
`timescale 1ns/1ps
module tb_fetch_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QUEUE_HW = 4;

  logic        Clk = 1'b0;
  logic        Reset, FetchEn, InstrValid, InstrReady, InstrIsC, RedirectValid;
  logic [31:0] FetchAddr, FetchData, Instr, InstrPc, RedirectPc;

  logic [31:0] rom [128];
  assign FetchData = rom[FetchAddr[8:2]];

  fetch_aligner #(.RESET_PC(RESET_PC), .QUEUE_HW(QUEUE_HW)) dut (
    .Clk(Clk), .Reset(Reset), .FetchAddr(FetchAddr), .FetchEn(FetchEn), .FetchData(FetchData),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrPc(InstrPc),
    .InstrIsC(InstrIsC), .RedirectValid(RedirectValid), .RedirectPc(RedirectPc)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_c;
  } exp_t;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = rom[a[8:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic exp_t model_at(input logic [31:0] pc);
    exp_t e;
`ifdef FETCH_RVC_EN
    logic [15:0] h0;
    e.pc = pc & 32'hFFFF_FFFE;
    h0   = hw_at(e.pc);
    if (h0[1:0] != 2'b11) begin
      e.instr = {16'h0, h0};
      e.is_c  = 1'b1;
    end else begin
      e.instr = {hw_at(e.pc + 32'd2), h0};
      e.is_c  = 1'b0;
    end
`else
    e.pc    = pc & 32'hFFFF_FFFC;
    e.instr = rom[e.pc[8:2]];
    e.is_c  = 1'b0;
`endif
    return e;
  endfunction

  exp_t sb_q[$];
  bit   sb_en = 1'b0;

  always @(negedge Clk) begin
    if (sb_en && !Reset) begin
      chk("addr_align", 32'(FetchAddr[1:0]), 32'h0);
      if (InstrValid && InstrReady && !RedirectValid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra actual_pc=%h expected=none", InstrPc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_instr", Instr, e.instr);
          chk("sb_pc", InstrPc, e.pc);
          chk("sb_isc", 32'(InstrIsC), 32'(e.is_c));
        end
      end
    end
  end

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] faddr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_c;
  } vec_t;

`ifdef FETCH_RVC_EN
  localparam int NV = 7;
`else
  localparam int NV = 5;
`endif
  vec_t vecs [NV];

  logic [31:0] starts [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int waited;
    logic [31:0] pc;
    exp_t e;

    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0]   = 32'h00A0_0093;
    rom[1]   = 32'h0010_0113;
    rom[2]   = 32'h0013_4501;
    rom[3]   = 32'h0000_0093;
    rom[4]   = 32'h0000_4501;
    rom[64]  = 32'h0513_ABCD;
    rom[65]  = 32'h0000_0297;
    rom[127] = 32'h0003_1111;

`ifdef FETCH_RVC_EN
    vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0297_0513, 32'h0000_0102, 1'b0};
    vecs[1] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_00A0, 32'h0000_0002, 1'b1};
    vecs[2] = '{32'h0000_0008, 32'h0000_0008, 32'h0000_4501, 32'h0000_0008, 1'b1};
    vecs[3] = '{32'h0000_000A, 32'h0000_0008, 32'h0093_0013, 32'h0000_000A, 1'b0};
    vecs[4] = '{32'h0000_0103, 32'h0000_0100, 32'h0297_0513, 32'h0000_0102, 1'b0};
    vecs[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0093_0003, 32'hFFFF_FFFE, 1'b0};
    vecs[6] = '{32'h0000_0010, 32'h0000_0010, 32'h0000_4501, 32'h0000_0010, 1'b1};
`else
    vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0513_ABCD, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'h0000_0006, 32'h0000_0004, 32'h0010_0113, 32'h0000_0004, 1'b0};
    vecs[2] = '{32'h0000_0010, 32'h0000_0010, 32'h0000_4501, 32'h0000_0010, 1'b0};
    vecs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0003_1111, 32'hFFFF_FFFC, 1'b0};
    vecs[4] = '{32'h0000_000B, 32'h0000_0008, 32'h0013_4501, 32'h0000_0008, 1'b0};
`endif
    starts[0] = 32'h0000_0000;
    starts[1] = 32'h0000_0002;
    starts[2] = 32'hFFFF_FFF0;
    starts[3] = 32'h0000_0046;

    Reset = 1'b1; InstrReady = 1'b0; RedirectValid = 1'b0; RedirectPc = 32'h0;
    repeat (2) @(posedge Clk);
    smp();
    chk("rst_valid", 32'(InstrValid), 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pc", InstrPc, RESET_PC);
    chk("rst_isc", 32'(InstrIsC), 32'h0);

    // Reset release with decode always ready
    nxt(); Reset = 1'b0; InstrReady = 1'b1;
    smp();
    chk("t1_first_fetchen", 32'(FetchEn), 32'h1);
    chk("t1_first_addr", FetchAddr, 32'h0);
    chk("t1_first_valid", 32'(InstrValid), 32'h0);
    nxt(); smp();
    chk("t1_i0_instr", Instr, 32'h00A0_0093);
    chk("t1_i0_pc", InstrPc, 32'h0);
    chk("t1_i0_valid", 32'(InstrValid), 32'h1);
    nxt(); smp();
    chk("t1_i1_instr", Instr, 32'h0010_0113);
    chk("t1_i1_pc", InstrPc, 32'h4);

    // Stall with a full queue
    nxt(); Reset = 1'b1; InstrReady = 1'b0;
    nxt(); Reset = 1'b0;
    nxt(); nxt();
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t3_fetchen", 32'(FetchEn), 32'h0);
      chk("t3_valid", 32'(InstrValid), 32'h1);
      chk("t3_instr", Instr, 32'h00A0_0093);
      chk("t3_pc", InstrPc, 32'h0);
      nxt();
    end

    // Redirect vectors; the first one lands while a handshake is offered
    for (int v = 0; v < NV; v++) begin
      nxt(); RedirectValid = 1'b1; RedirectPc = vecs[v].rpc; InstrReady = 1'b1;
      smp();
      if (v == 0) chk("t4_valid_at_redirect", 32'(InstrValid), 32'h1);
      chk("redir_fetch_blocked", 32'(FetchEn), 32'h0);
      nxt(); RedirectValid = 1'b0; InstrReady = 1'b0;
      smp();
      chk("post_redir_valid", 32'(InstrValid), 32'h0);
      chk("post_redir_fetchen", 32'(FetchEn), 32'h1);
      chk("post_redir_addr", FetchAddr, vecs[v].faddr);
      waited = 0;
      while (!InstrValid && waited < 6) begin
        nxt(); smp();
        waited++;
      end
      chk("vec_valid_in_time", 32'(InstrValid), 32'h1);
      chk("vec_instr", Instr, vecs[v].instr);
      chk("vec_pc", InstrPc, vecs[v].pc);
      chk("vec_isc", 32'(InstrIsC), 32'(vecs[v].is_c));
    end

    // Scoreboard streams with random back-pressure
    for (int s = 0; s < 4; s++) begin
      nxt(); RedirectValid = 1'b1; RedirectPc = starts[s]; InstrReady = 1'b0;
      pc = starts[s];
      for (int k = 0; k < 24; k++) begin
        e = model_at(pc);
        sb_q.push_back(e);
        pc = e.pc + (e.is_c ? 32'd2 : 32'd4);
      end
      nxt(); RedirectValid = 1'b0; sb_en = 1'b1;
      waited = 0;
      while (sb_q.size() > 0 && waited < 600) begin
        InstrReady = ($urandom_range(0, 3) != 0);
        nxt();
        waited++;
      end
      InstrReady = 1'b0;
      sb_en = 1'b0;
      if (sb_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL sb_timeout actual_left=%0d expected=0", sb_q.size());
        sb_q.delete();
      end
    end

    // Reset while the next instruction is still split across words
    nxt(); RedirectValid = 1'b1; RedirectPc = 32'h0000_0102;
    nxt(); RedirectValid = 1'b0;
    nxt(); smp();
`ifdef FETCH_RVC_EN
    chk("t5_split_valid", 32'(InstrValid), 32'h0);
`else
    chk("t5_pre_valid", 32'(InstrValid), 32'h1);
    chk("t5_pre_instr", Instr, 32'h0513_ABCD);
`endif
    #1 Reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(InstrValid), 32'h0);
    chk("t5_rst_instr", Instr, 32'h0);
    chk("t5_rst_pc", InstrPc, RESET_PC);
    chk("t5_rst_addr", FetchAddr, RESET_PC & 32'hFFFF_FFFC);
    nxt(); Reset = 1'b0;
    smp();
    chk("t5_restart_addr", FetchAddr, 32'h0);
    chk("t5_restart_fetchen", 32'(FetchEn), 32'h1);
    nxt(); smp();
    chk("t5_restart_instr", Instr, 32'h00A0_0093);
    chk("t5_restart_pc", InstrPc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
